// File: rtl/button_reader_pkg.sv
// rtl/button_reader_pkg.sv - shared FSM state encoding and debounce default
package button_reader_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED      = 2'd0,
    ST_PRESS_CHECK   = 2'd1,
    ST_PRESSED       = 2'd2,
    ST_RELEASE_CHECK = 2'd3
  } btn_state_e;

  // 10 ms at a 12 MHz system clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = 120000;

endpackage

// File: rtl/button_reader_sync_2ff.sv
// rtl/button_reader_sync_2ff.sv - two-flop synchronizer for an asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_out = s2_q;

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounced push-button reader with press/release strobes
// and a 4-bit press counter.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic       BTN_IN,
  output logic       BTN_LEVEL,
  output logic       PRESS_PULSE,
  output logic       RELEASE_PULSE,
  output logic [3:0] PRESS_COUNT
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic synced;

  sync_2ff u_sync (
    .clk   (CLK_IN),
    .rst   (RST_IN),
    .d_in  (BTN_IN),
    .q_out (synced)
  );

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic [3:0]       count_q, count_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_RELEASED: begin
        if (synced) begin
          state_d = ST_PRESS_CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS_CHECK: begin
        if (!synced) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          count_d = count_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!synced) begin
          state_d = ST_RELEASE_CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RELEASE_CHECK: begin
        if (synced) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
    // Level tracks the confirmed state, so a release bounce keeps it high
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_CHECK);
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      count_q <= count_d;
    end
  end

  assign BTN_LEVEL     = level_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = rel_q;
  assign PRESS_COUNT   = count_q;

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - directed bench for button_reader with a run-length
// reference model compared every cycle.
module tb_button_reader;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [3:0] press_count;

  int checks = 0;
  int errors = 0;
  int press_seen = 0;
  int rel_seen = 0;

  button_reader #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK_IN        (clk),
    .RST_IN        (rst),
    .BTN_IN        (btn),
    .BTN_LEVEL     (btn_level),
    .PRESS_PULSE   (press_pulse),
    .RELEASE_PULSE (release_pulse),
    .PRESS_COUNT   (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the debounced level flips once N consecutive synced samples
  // disagree with it; the synced level is the raw input two edges late.
  logic       m_s1, m_s2, smp, run_val, m_deb, exp_press, exp_rel;
  int         run_len;
  logic [3:0] exp_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; run_val = 0; run_len = 0; m_deb = 0;
      exp_press = 0; exp_rel = 0; exp_cnt = 0;
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = btn;
      if (smp == run_val) begin
        if (run_len < N) run_len = run_len + 1;
      end else begin
        run_val = smp;
        run_len = 1;
      end
      exp_press = 0;
      exp_rel   = 0;
      if (run_len == N && run_val != m_deb) begin
        m_deb = run_val;
        if (run_val) begin
          exp_press = 1;
          exp_cnt   = exp_cnt + 4'd1;
        end else begin
          exp_rel = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    checks = checks + 4;
    if (btn_level !== m_deb) begin
      errors++; $display("FAIL model_level actual=%0b expected=%0b t=%0t", btn_level, m_deb, $time);
    end
    if (press_pulse !== exp_press) begin
      errors++; $display("FAIL model_press actual=%0b expected=%0b t=%0t", press_pulse, exp_press, $time);
    end
    if (release_pulse !== exp_rel) begin
      errors++; $display("FAIL model_release actual=%0b expected=%0b t=%0t", release_pulse, exp_rel, $time);
    end
    if (press_count !== exp_cnt) begin
      errors++; $display("FAIL model_count actual=%0d expected=%0d t=%0t", press_count, exp_cnt, $time);
    end
    checks++;
    if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
      errors++; $display("FAIL pulse_exclusive actual=11 expected=not both t=%0t", $time);
    end
    if (press_pulse === 1'b1) press_seen++;
    if (release_pulse === 1'b1) rel_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0, r0;

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    step(3);
    chk("reset_level", btn_level, 0);
    chk("reset_press", press_pulse, 0);
    chk("reset_release", release_pulse, 0);
    chk("reset_count", press_count, 0);
    rst = 1'b0;
    step(3);

    // Clean press: edge 0 is the first posedge after this drive
    btn = 1'b1;
    step(5);
    chk("press_before_latency", press_pulse, 0);
    chk("level_before_latency", btn_level, 0);
    step(1);
    chk("press_at_latency", press_pulse, 1);
    chk("level_at_latency", btn_level, 1);
    chk("count_after_press", press_count, 1);
    step(1);
    chk("press_one_cycle", press_pulse, 0);
    chk("level_held", btn_level, 1);

    // Clean release
    btn = 1'b0;
    step(5);
    chk("release_before_latency", release_pulse, 0);
    step(1);
    chk("release_at_latency", release_pulse, 1);
    chk("level_after_release", btn_level, 0);
    chk("count_kept_on_release", press_count, 1);
    step(3);

    // Bounce: 3 high, 2 low, then held
    p0 = press_seen;
    btn = 1'b1; step(3);
    btn = 1'b0; step(2);
    btn = 1'b1; step(5);
    chk("bounce_no_early_press", press_pulse, 0);
    chk("bounce_no_level", btn_level, 0);
    step(1);
    chk("bounce_press", press_pulse, 1);
    chk("bounce_count", press_count, 2);
    step(5);
    chk("bounce_single_pulse", press_seen - p0, 1);
    btn = 1'b0;
    step(10);

    // Reset between edges 3 and 4 of a press
    btn = 1'b1;
    step(4);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_level", btn_level, 0);
    chk("rst_mid_press", press_pulse, 0);
    chk("rst_mid_count", press_count, 0);
    step(2);
    rst = 1'b0;
    step(5);
    chk("rst_mid_no_early", press_pulse, 0);
    step(1);
    chk("rst_mid_press_after", press_pulse, 1);
    chk("rst_mid_count_after", press_count, 1);

    // Reset during the pulse cycle, button held through reset
    rst = 1'b1;
    #1;
    chk("rst_pulse_press", press_pulse, 0);
    chk("rst_pulse_level", btn_level, 0);
    chk("rst_pulse_count", press_count, 0);
    step(2);
    rst = 1'b0;
    step(5);
    chk("held_no_early", press_pulse, 0);
    step(1);
    chk("held_new_press", press_pulse, 1);
    chk("held_count", press_count, 1);
    btn = 1'b0;
    step(10);

    // Counter wrap over 17 presses
    rst = 1'b1; step(2);
    rst = 1'b0; step(2);
    p0 = press_seen;
    r0 = rel_seen;
    for (int i = 0; i < 17; i++) begin
      btn = 1'b1;
      step(6);
      chk("wrap_count", press_count, (i + 1) % 16);
      step(2);
      btn = 1'b0;
      step(8);
    end
    chk("wrap_press_total", press_seen - p0, 17);
    chk("wrap_release_total", rel_seen - r0, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
